ethernet_tx_scheduler: RTL and testbench
========================================

Name: ethernet_tx_scheduler

Overview:
Front-end controller for the single Ethernet TX engine (MAC-side RMII transmitter).
- Arbitrates N_QUEUES transmit queues, each a descriptor stream plus a payload byte stream.
- Latches the winning descriptor and muxes that queue's payload bytes to the engine.
- Generates the engine's dibit strobe (transmit), which sets the RMII rate.
- Tracks frame completion and status (frames sent, drops, underruns).

Parameters:
N_QUEUES, 2, number of requesting queues (2..4); queue 0 has highest strict priority.
CLK_DIV, 2, clk_i cycles per RMII dibit; strobe period; must be >= 1.
MAX_PAYLOAD, 1500, largest accepted payload length in bytes.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous, active-low
enable_i  in  1  global enable; low freezes the strobe and blocks new grants
strict_prio_i  in  1  1 = strict priority, 0 = round-robin
desc_valid_i  in  N_QUEUES  per-queue descriptor available
desc_dest_i  in  N_QUEUES x 48  per-queue destination MAC
desc_length_i  in  N_QUEUES x 16  per-queue payload length, bytes
desc_eth2_i  in  N_QUEUES  per-queue Ethernet II framing flag
desc_ack_o  out  N_QUEUES  one-cycle pulse: descriptor consumed (sent or dropped)
data_valid_i  in  N_QUEUES  per-queue payload byte available
data_i  in  N_QUEUES x 8  per-queue payload byte
data_pop_o  out  N_QUEUES  per-queue byte pop (combinational from engine read)
eng_transmit_o  out  1  dibit strobe to engine
eng_ethernet_II_o  out  1  latched framing flag
eng_dest_o  out  48  latched destination MAC
eng_length_o  out  16  latched payload length
eng_data_ready_o  out  1  granted queue has a byte and scheduler is armed
eng_payload_o  out  8  granted queue's current byte
eng_read_data_i  in  1  engine pops a payload byte
eng_read_descriptor_i  in  1  engine accepted the descriptor (frame start)
eng_idle_i  in  1  engine idle
busy_o  out  1  scheduler not in IDLE
grant_o  out  2  queue currently granted
frames_sent_o  out  32  wrapping count of completed frames
frames_dropped_o  out  16  wrapping count of rejected descriptors
underrun_o  out  1  sticky; cleared only by reset

Behaviour:
- Reset values: all outputs 0; state IDLE; strobe counter 0; round-robin pointer 0.
- Strobe generation:
  - Counter runs 0..CLK_DIV-1 while enable_i=1 and holds its value while enable_i=0.
  - eng_transmit_o=1 in the cycle the counter equals CLK_DIV-1 and enable_i=1.
  - With CLK_DIV=1 the strobe is constant 1 while enabled.
- IDLE:
  - When enable_i=1, eng_idle_i=1 and any desc_valid_i is set, the arbiter picks a winner.
  - Strict mode: lowest index wins.
  - Round-robin mode: first valid queue at or after the pointer, wrapping.
  - Register the winner into grant_o and go to CHECK (1 cycle).
- CHECK: validate the latched length.
  - If length==0 or length>MAX_PAYLOAD: desc_ack_o[grant]=1, frames_dropped_o+1, no bytes popped, return to IDLE.
  - Otherwise latch dest/length/eth2 onto the eng_* outputs and go to ARM.
- ARM:
  - eng_data_ready_o = data_valid_i[grant].
  - eng_read_descriptor_i=1 → go to ACTIVE.
  - No timeout; enable_i=0 stalls here indefinitely.
- ACTIVE:
  - eng_data_ready_o = data_valid_i[grant]; eng_payload_o = data_i[grant].
  - data_pop_o[grant] = eng_read_data_i, asserted in the same cycle (also in ARM, for the first byte).
  - eng_read_data_i=1 while data_valid_i[grant]=0: set underrun_o; the frame continues with the stale byte; no pop is issued.
  - eng_idle_i rising (0 in the previous cycle, 1 now) → DONE.
- DONE (1 cycle):
  - desc_ack_o[grant]=1 and frames_sent_o+1.
  - Round-robin pointer = grant+1 mod N_QUEUES.
  - Return to IDLE.
  - Earliest next grant is the following cycle.
- Descriptor/payload fields are read only in CHECK. The requester holds them stable until desc_ack_o.
- Outputs to non-granted queues: data_pop_o and desc_ack_o are always 0.
- In IDLE and CHECK: eng_data_ready_o=0 and eng_payload_o=0.
- The latched eng_* fields stay constant from ARM through DONE.
- Boundary cases:
  - A descriptor deasserted in the same cycle as arbitration still counts as granted; requesters must not withdraw valid.
  - Reset mid-frame returns to IDLE with no ack; counters cleared.

Decomposition:
- ethernet_pkg additions: MAX_PAYLOAD_BYTES=1500; typedef tx_descriptor_t (dest[5:0][7:0], length[1:0][7:0], eth2); typedef tx_sched_states_t {IDLE, CHECK, ARM, ACTIVE, DONE}.
- Sub-module ethernet_tx_arbiter: combinational strict/round-robin winner select from a valid vector, pointer and mode; outputs winner index and any-valid.

Test Plan:
- Q0 desc len=64, eth2=0, 64 bytes ready; model engine → exactly 64 data_pop_o[0] pulses, one desc_ack_o[0] after eng_idle_i rises, frames_sent_o=1.
- CLK_DIV=2, enable_i toggled low for 5 cycles → strobe every 2nd cycle when enabled, none while disabled, phase preserved.
- Both queues valid continuously, strict_prio_i=0, 4 frames → grant order 0,1,0,1; with strict_prio_i=1 → 0,0,0,0.
- Q1 desc len=0, then len=1501 → two desc_ack_o[1] pulses, frames_dropped_o=2, zero pops, engine never sees eng_data_ready_o.
- Q0 len=10, only 5 bytes supplied, engine reads 10 → underrun_o=1 sticky, exactly 5 pops, frame still acked.
- Assert rst_n_i low during ACTIVE → all outputs 0 asynchronously, no ack; after release a new grant starts from IDLE.

Source files
------------

// File: rtl/ethernet_tx_scheduler_pkg.sv
// Shared types and constants for the Ethernet TX scheduler.
// Provides the descriptor payload struct, the scheduler state encoding,
// the default payload length limit and the grant index width.
package ethernet_tx_scheduler_pkg;

    localparam int unsigned MAX_PAYLOAD_BYTES = 1500;
    localparam int unsigned GRANT_W           = 2;

    typedef struct packed {
        logic [5:0][7:0] dest;
        logic [1:0][7:0] length;
        logic            eth2;
    } tx_descriptor_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ARM,
        ACTIVE,
        DONE
    } tx_sched_states_t;

endpackage

// File: rtl/ethernet_tx_arbiter.sv
// Combinational queue arbiter for the TX scheduler.
// Ports: valid (per-queue request), ptr (round-robin start index),
// strict_prio (1 = lowest index wins), winner (selected index),
// any_valid (at least one request present).
module ethernet_tx_arbiter #(
    parameter int unsigned N_QUEUES = 2,
    parameter int unsigned GRANT_W  = 2
) (
    input  logic [N_QUEUES-1:0] valid,
    input  logic [GRANT_W-1:0]  ptr,
    input  logic                strict_prio,
    output logic [GRANT_W-1:0]  winner,
    output logic                any_valid
);

    logic [N_QUEUES-1:0] rotated;
    logic                found;

    // Rotating the request vector puts the pointer queue at bit 0,
    // so both modes reduce to a lowest-set-bit search.
    always_comb begin
        rotated = N_QUEUES'({valid, valid} >> ptr);
        winner  = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_QUEUES; i++) begin
            if (strict_prio) begin
                if (!found && valid[i]) begin
                    winner = GRANT_W'(i);
                    found  = 1'b1;
                end
            end else if (!found && rotated[i]) begin
                winner = GRANT_W'((32'(ptr) + i) % N_QUEUES);
                found  = 1'b1;
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/ethernet_tx_scheduler.sv
// Front-end scheduler for the single RMII TX engine.
// Inputs: per-queue descriptor/payload streams, engine handshakes
// (read_descriptor, read_data, idle), enable and priority mode.
// Outputs: dibit strobe, latched descriptor fields, muxed payload byte,
// per-queue pops/acks, grant, busy and frame status counters.
module ethernet_tx_scheduler
    import ethernet_tx_scheduler_pkg::*;
#(
    parameter int unsigned N_QUEUES    = 2,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_BYTES
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      enable_i,
    input  logic                      strict_prio_i,
    input  logic [N_QUEUES-1:0]       desc_valid_i,
    input  logic [N_QUEUES-1:0][47:0] desc_dest_i,
    input  logic [N_QUEUES-1:0][15:0] desc_length_i,
    input  logic [N_QUEUES-1:0]       desc_eth2_i,
    output logic [N_QUEUES-1:0]       desc_ack_o,
    input  logic [N_QUEUES-1:0]       data_valid_i,
    input  logic [N_QUEUES-1:0][7:0]  data_i,
    output logic [N_QUEUES-1:0]       data_pop_o,
    output logic                      eng_transmit_o,
    output logic                      eng_ethernet_II_o,
    output logic [47:0]               eng_dest_o,
    output logic [15:0]               eng_length_o,
    output logic                      eng_data_ready_o,
    output logic [7:0]                eng_payload_o,
    input  logic                      eng_read_data_i,
    input  logic                      eng_read_descriptor_i,
    input  logic                      eng_idle_i,
    output logic                      busy_o,
    output logic [GRANT_W-1:0]        grant_o,
    output logic [31:0]               frames_sent_o,
    output logic [15:0]               frames_dropped_o,
    output logic                      underrun_o
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    tx_sched_states_t   state_q, state_d;
    logic [CNT_W-1:0]   strobe_cnt;
    logic [GRANT_W-1:0] grant_q, rr_ptr_q, arb_winner;
    logic               arb_any, eng_idle_q;
    tx_descriptor_t     sel_desc, eng_desc_q;
    logic               sel_data_valid;
    logic [7:0]         sel_data;
    logic               len_bad;
    logic               grant_en, drop_en, latch_en, done_en, underrun_set;
    logic               pop_en, ack_en;

    ethernet_tx_arbiter #(
        .N_QUEUES (N_QUEUES),
        .GRANT_W  (GRANT_W)
    ) u_arbiter (
        .valid       (desc_valid_i),
        .ptr         (rr_ptr_q),
        .strict_prio (strict_prio_i),
        .winner      (arb_winner),
        .any_valid   (arb_any)
    );

    // Dibit strobe: free-running divider that freezes while disabled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            strobe_cnt <= '0;
        end else if (enable_i) begin
            strobe_cnt <= (strobe_cnt == CNT_W'(CLK_DIV - 1)) ? '0 : strobe_cnt + CNT_W'(1);
        end
    end

    assign eng_transmit_o = enable_i && (strobe_cnt == CNT_W'(CLK_DIV - 1));

    // Granted-queue mux for descriptor and payload inputs.
    always_comb begin
        sel_desc       = '0;
        sel_data_valid = 1'b0;
        sel_data       = '0;
        for (int unsigned i = 0; i < N_QUEUES; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                sel_desc.dest   = desc_dest_i[i];
                sel_desc.length = desc_length_i[i];
                sel_desc.eth2   = desc_eth2_i[i];
                sel_data_valid  = data_valid_i[i];
                sel_data        = data_i[i];
            end
        end
    end

    assign len_bad = (sel_desc.length == '0) || (32'(sel_desc.length) > MAX_PAYLOAD);

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and engine/queue handshake decode.
    always_comb begin
        state_d          = state_q;
        grant_en         = 1'b0;
        drop_en          = 1'b0;
        latch_en         = 1'b0;
        done_en          = 1'b0;
        underrun_set     = 1'b0;
        pop_en           = 1'b0;
        ack_en           = 1'b0;
        eng_data_ready_o = 1'b0;
        eng_payload_o    = '0;
        data_pop_o       = '0;
        desc_ack_o       = '0;
        unique case (state_q)
            IDLE: begin
                if (enable_i && eng_idle_i && arb_any) begin
                    grant_en = 1'b1;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (len_bad) begin
                    ack_en  = 1'b1;
                    drop_en = 1'b1;
                    state_d = IDLE;
                end else begin
                    latch_en = 1'b1;
                    state_d  = ARM;
                end
            end
            ARM, ACTIVE: begin
                eng_data_ready_o = sel_data_valid;
                eng_payload_o    = sel_data;
                pop_en           = eng_read_data_i && sel_data_valid;
                underrun_set     = eng_read_data_i && !sel_data_valid;
                if (state_q == ARM) begin
                    if (eng_read_descriptor_i) begin
                        state_d = ACTIVE;
                    end
                end else if (eng_idle_i && !eng_idle_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ack_en  = 1'b1;
                done_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        for (int unsigned i = 0; i < N_QUEUES; i++) begin
            data_pop_o[i] = pop_en && (grant_q == GRANT_W'(i));
            desc_ack_o[i] = ack_en && (grant_q == GRANT_W'(i));
        end
    end

    // Grant, pointer, latched descriptor and status counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            grant_q          <= '0;
            rr_ptr_q         <= '0;
            eng_desc_q       <= '0;
            eng_idle_q       <= 1'b0;
            frames_sent_o    <= '0;
            frames_dropped_o <= '0;
            underrun_o       <= 1'b0;
        end else begin
            eng_idle_q <= eng_idle_i;
            if (grant_en) begin
                grant_q <= arb_winner;
            end
            if (latch_en) begin
                eng_desc_q <= sel_desc;
            end
            if (drop_en) begin
                frames_dropped_o <= frames_dropped_o + 16'd1;
            end
            if (done_en) begin
                frames_sent_o <= frames_sent_o + 32'd1;
                rr_ptr_q      <= (grant_q == GRANT_W'(N_QUEUES - 1)) ? '0 : grant_q + GRANT_W'(1);
            end
            if (underrun_set) begin
                underrun_o <= 1'b1;
            end
        end
    end

    assign busy_o            = (state_q != IDLE);
    assign grant_o           = grant_q;
    assign eng_dest_o        = eng_desc_q.dest;
    assign eng_length_o      = eng_desc_q.length;
    assign eng_ethernet_II_o = eng_desc_q.eth2;

endmodule

// File: tb/tb_ethernet_tx_scheduler.sv
// Directed self-checking bench for ethernet_tx_scheduler (2 queues, CLK_DIV=2).
module tb_ethernet_tx_scheduler;

    logic             clk_i;
    logic             rst_n_i;
    logic             enable_i;
    logic             strict_prio_i;
    logic [1:0]       desc_valid_i;
    logic [1:0][47:0] desc_dest_i;
    logic [1:0][15:0] desc_length_i;
    logic [1:0]       desc_eth2_i;
    logic [1:0]       desc_ack_o;
    logic [1:0]       data_valid_i;
    logic [1:0][7:0]  data_i;
    logic [1:0]       data_pop_o;
    logic             eng_transmit_o;
    logic             eng_ethernet_II_o;
    logic [47:0]      eng_dest_o;
    logic [15:0]      eng_length_o;
    logic             eng_data_ready_o;
    logic [7:0]       eng_payload_o;
    logic             eng_read_data_i;
    logic             eng_read_descriptor_i;
    logic             eng_idle_i;
    logic             busy_o;
    logic [1:0]       grant_o;
    logic [31:0]      frames_sent_o;
    logic [15:0]      frames_dropped_o;
    logic             underrun_o;

    int checks;
    int errors;
    int pop_cnt [2];
    int ack_cnt [2];
    int ready_cnt;

    ethernet_tx_scheduler #(
        .N_QUEUES    (2),
        .CLK_DIV     (2),
        .MAX_PAYLOAD (1500)
    ) dut (
        .clk_i                 (clk_i),
        .rst_n_i               (rst_n_i),
        .enable_i              (enable_i),
        .strict_prio_i         (strict_prio_i),
        .desc_valid_i          (desc_valid_i),
        .desc_dest_i           (desc_dest_i),
        .desc_length_i         (desc_length_i),
        .desc_eth2_i           (desc_eth2_i),
        .desc_ack_o            (desc_ack_o),
        .data_valid_i          (data_valid_i),
        .data_i                (data_i),
        .data_pop_o            (data_pop_o),
        .eng_transmit_o        (eng_transmit_o),
        .eng_ethernet_II_o     (eng_ethernet_II_o),
        .eng_dest_o            (eng_dest_o),
        .eng_length_o          (eng_length_o),
        .eng_data_ready_o      (eng_data_ready_o),
        .eng_payload_o         (eng_payload_o),
        .eng_read_data_i       (eng_read_data_i),
        .eng_read_descriptor_i (eng_read_descriptor_i),
        .eng_idle_i            (eng_idle_i),
        .busy_o                (busy_o),
        .grant_o               (grant_o),
        .frames_sent_o         (frames_sent_o),
        .frames_dropped_o      (frames_dropped_o),
        .underrun_o            (underrun_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Event counters observed at the active edge.
    always @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (data_pop_o[i]) pop_cnt[i] <= pop_cnt[i] + 1;
            if (desc_ack_o[i]) ack_cnt[i] <= ack_cnt[i] + 1;
        end
        if (eng_data_ready_o) ready_cnt <= ready_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    // Entered at the negedge of an IDLE cycle with the descriptor driven;
    // returns #1 after the negedge of the DONE cycle.
    task automatic do_frame(input logic q, input int len, input int avail, input int nread);
        int left;
        left = avail;
        @(negedge clk_i); #1;
        chk("check_grant", 64'(grant_o), 64'(q));
        chk("check_busy", 64'(busy_o), 64'd1);
        chk("check_no_ack", 64'(desc_ack_o), 64'd0);
        chk("check_no_ready", 64'(eng_data_ready_o), 64'd0);
        @(negedge clk_i); #1;
        chk("arm_length", 64'(eng_length_o), 64'(len));
        eng_read_descriptor_i = 1'b1;
        eng_idle_i            = 1'b0;
        @(negedge clk_i);
        eng_read_descriptor_i = 1'b0;
        for (int r = 0; r < nread; r++) begin
            data_valid_i[q] = (left > 0);
            data_i[q]       = 8'(r + 1);
            eng_read_data_i = 1'b1;
            if (r == 0 && left > 0) begin
                #1;
                chk("active_ready", 64'(eng_data_ready_o), 64'd1);
                chk("active_payload", 64'(eng_payload_o), 64'd1);
                chk("active_pop", 64'(data_pop_o), 64'(2'b01 << q));
            end
            @(negedge clk_i);
            if (left > 0) left--;
        end
        eng_read_data_i = 1'b0;
        data_valid_i[q] = 1'b0;
        eng_idle_i      = 1'b1;
        @(negedge clk_i); #1;
        chk("done_ack", 64'(desc_ack_o), 64'(2'b01 << q));
    endtask

    initial begin
        int p0, p1, a0, a1, rd;
        int ph;
        logic exp_tx;

        checks                = 0;
        errors                = 0;
        rst_n_i               = 1'b0;
        enable_i              = 1'b0;
        strict_prio_i         = 1'b1;
        desc_valid_i          = '0;
        desc_dest_i           = '0;
        desc_length_i         = '0;
        desc_eth2_i           = '0;
        data_valid_i          = '0;
        data_i                = '0;
        eng_read_data_i       = 1'b0;
        eng_read_descriptor_i = 1'b0;
        eng_idle_i            = 1'b1;

        // Reset values.
        @(negedge clk_i);
        @(negedge clk_i); #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_sent", 64'(frames_sent_o), 64'd0);
        chk("rst_dropped", 64'(frames_dropped_o), 64'd0);
        chk("rst_underrun", 64'(underrun_o), 64'd0);
        chk("rst_dest", 64'(eng_dest_o), 64'd0);
        chk("rst_length", 64'(eng_length_o), 64'd0);
        chk("rst_ack", 64'(desc_ack_o), 64'd0);
        chk("rst_pop", 64'(data_pop_o), 64'd0);
        chk("rst_transmit", 64'(eng_transmit_o), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Strobe every second enabled cycle, frozen for 5 disabled cycles.
        ph = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            enable_i = !(c >= 7 && c < 12);
            #1;
            exp_tx = enable_i && (ph == 1);
            chk("strobe", 64'(eng_transmit_o), 64'(exp_tx));
            if (enable_i) ph = (ph + 1) % 2;
        end

        // Q0 64-byte frame.
        p0 = pop_cnt[0]; a0 = ack_cnt[0];
        desc_dest_i[0]   = 48'h112233445566;
        desc_length_i[0] = 16'd64;
        desc_eth2_i[0]   = 1'b0;
        desc_valid_i     = 2'b01;
        do_frame(1'b0, 64, 64, 64);
        chk("q0_dest", 64'(eng_dest_o), 64'h112233445566);
        chk("q0_eth2", 64'(eng_ethernet_II_o), 64'd0);
        desc_valid_i = 2'b00;
        @(negedge clk_i); #1;
        chk("q0_pops", 64'(pop_cnt[0] - p0), 64'd64);
        chk("q0_acks", 64'(ack_cnt[0] - a0), 64'd1);
        chk("q0_sent", 64'(frames_sent_o), 64'd1);
        chk("q0_idle", 64'(busy_o), 64'd0);
        chk("q0_underrun", 64'(underrun_o), 64'd0);

        // Round-robin then strict with both queues continuously valid.
        do_reset();
        desc_length_i[0] = 16'd4;
        desc_length_i[1] = 16'd4;
        strict_prio_i    = 1'b0;
        desc_valid_i     = 2'b11;
        do_frame(1'b0, 4, 4, 4);
        @(negedge clk_i);
        do_frame(1'b1, 4, 4, 4);
        @(negedge clk_i);
        do_frame(1'b0, 4, 4, 4);
        @(negedge clk_i);
        do_frame(1'b1, 4, 4, 4);
        @(negedge clk_i);
        strict_prio_i = 1'b1;
        for (int f = 0; f < 4; f++) begin
            do_frame(1'b0, 4, 4, 4);
            @(negedge clk_i);
        end
        desc_valid_i = 2'b00;
        @(negedge clk_i); #1;
        chk("arb_sent", 64'(frames_sent_o), 64'd8);

        // Q1 zero-length then oversize descriptor are both dropped.
        p1 = pop_cnt[1]; a1 = ack_cnt[1]; rd = ready_cnt;
        desc_length_i[1] = 16'd0;
        desc_valid_i     = 2'b10;
        @(negedge clk_i); #1;
        chk("drop0_ack", 64'(desc_ack_o), 64'b10);
        chk("drop0_busy", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        desc_length_i[1] = 16'd1501;
        @(negedge clk_i); #1;
        chk("drop1_ack", 64'(desc_ack_o), 64'b10);
        @(negedge clk_i);
        desc_valid_i = 2'b00;
        @(negedge clk_i); #1;
        chk("drop_count", 64'(frames_dropped_o), 64'd2);
        chk("drop_acks", 64'(ack_cnt[1] - a1), 64'd2);
        chk("drop_pops", 64'(pop_cnt[1] - p1), 64'd0);
        chk("drop_ready", 64'(ready_cnt - rd), 64'd0);
        chk("drop_sent", 64'(frames_sent_o), 64'd8);

        // Q0 underrun: 10 reads against 5 supplied bytes.
        p0 = pop_cnt[0]; a0 = ack_cnt[0];
        desc_length_i[0] = 16'd10;
        desc_valid_i     = 2'b01;
        do_frame(1'b0, 10, 5, 10);
        desc_valid_i = 2'b00;
        @(negedge clk_i); #1;
        chk("ur_flag", 64'(underrun_o), 64'd1);
        chk("ur_pops", 64'(pop_cnt[0] - p0), 64'd5);
        chk("ur_acks", 64'(ack_cnt[0] - a0), 64'd1);
        @(negedge clk_i);
        @(negedge clk_i); #1;
        chk("ur_sticky", 64'(underrun_o), 64'd1);

        // Reset asserted while Q1 is ACTIVE.
        desc_length_i[1] = 16'd8;
        desc_eth2_i[1]   = 1'b1;
        desc_valid_i     = 2'b10;
        @(negedge clk_i);
        @(negedge clk_i);
        eng_read_descriptor_i = 1'b1;
        eng_idle_i            = 1'b0;
        @(negedge clk_i);
        eng_read_descriptor_i = 1'b0;
        data_valid_i[1]       = 1'b1;
        eng_read_data_i       = 1'b1;
        a1 = ack_cnt[1];
        #2 rst_n_i = 1'b0;
        #1;
        chk("mid_busy", 64'(busy_o), 64'd0);
        chk("mid_grant", 64'(grant_o), 64'd0);
        chk("mid_length", 64'(eng_length_o), 64'd0);
        chk("mid_pop", 64'(data_pop_o), 64'd0);
        chk("mid_ack", 64'(desc_ack_o), 64'd0);
        chk("mid_ready", 64'(eng_data_ready_o), 64'd0);
        chk("mid_underrun", 64'(underrun_o), 64'd0);
        chk("mid_sent", 64'(frames_sent_o), 64'd0);
        @(negedge clk_i);
        eng_read_data_i = 1'b0;
        data_valid_i    = 2'b00;
        eng_idle_i      = 1'b1;
        rst_n_i         = 1'b1;
        #1;
        chk("mid_no_ack", 64'(ack_cnt[1] - a1), 64'd0);
        do_frame(1'b1, 8, 8, 8);
        chk("post_eth2", 64'(eng_ethernet_II_o), 64'd1);
        desc_valid_i = 2'b00;
        @(negedge clk_i); #1;
        chk("post_sent", 64'(frames_sent_o), 64'd1);
        chk("post_acks", 64'(ack_cnt[1] - a1), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
